pipeline_seq_controller: RTL and testbench
==========================================

// Module: pipeline_seq_controller
// PURPOSE
//  Parametrised sequencer for the encode/bus/decode test pipeline. Fills N_STAGES enable
//  stages one phase at a time, fires a trigger window, hands off to the TX path, and
//  repeats for a programmable number of bursts. Adds stall, TX timeout/error, burst count.
// PARAMETERS
//  N_STAGES     5     number of pipeline enable stages (>=1)
//  PHASE_LEN    2048  cycles per fill phase (>=2); CNT_W = $clog2(PHASE_LEN)
//  TRIG_LO      1     first phase-count value with trigger high (stage 0 only)
//  TRIG_HI      3     last phase-count value with trigger high (TRIG_LO<=TRIG_HI<PHASE_LEN)
//  BURST_W      8     width of n_bursts / burst_idx
//  TX_TIMEOUT   4096  max cycles spent in TX_WAIT before error (>=2)
//  RESTART_FILL 1     1: each burst refills from stage 0; 0: later bursts run at full depth
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         reset, synchronous, active-low
//  valid_in      in   1         start request, sampled in IDLE only
//  n_bursts      in   BURST_W   burst count, latched on start; 0 treated as 1
//  stall         in   1         freeze phase counter, gate enables
//  tx_finish     in   1         TX path finished, sampled in TX_WAIT only
//  clear_err     in   1         leave ERROR
//  en_stage      out  N_STAGES  thermometer stage enables, bit0 = first stage
//  trigger       out  1         capture trigger window
//  start_tx      out  1         1-cycle pulse, first cycle of TX_WAIT
//  done          out  1         1-cycle pulse, first cycle back in IDLE after last burst
//  busy          out  1         state != IDLE
//  error_timeout out  1         high while in ERROR
//  burst_idx     out  BURST_W   current burst number, 0-based
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, stage_idx=0, burst_idx=0, all outputs 0. Reset mid-op aborts.
//  - Outputs are Moore decodes of registered state; start_tx/done are registered pulses.
//  - IDLE: en_stage=0. valid_in -> FILL; latch nb=max(n_bursts,1); cnt=0, stage_idx=0, burst_idx=0.
//  - FILL: en_stage = (stage_idx+1) low bits set, forced 0 while stall.
//    !stall: cnt++; at cnt==PHASE_LEN-1: if stage_idx<N_STAGES-1 {stage_idx++, cnt=0}
//    else -> TX_WAIT (tmo=0). stall: cnt, stage_idx held; no transition.
//  - trigger = FILL & !stall & stage_idx==0 & burst_idx==0 & TRIG_LO<=cnt<=TRIG_HI.
//  - TX_WAIT: en_stage=0, tmo++ each cycle. tx_finish (incl. first cycle):
//    burst_idx==nb-1 -> IDLE with done pulse; else burst_idx++, cnt=0, -> FILL with
//    stage_idx=0 (RESTART_FILL=1) or N_STAGES-1 (RESTART_FILL=0).
//    tmo==TX_TIMEOUT-1 without tx_finish -> ERROR. tx_finish same cycle wins over timeout.
//  - ERROR: en_stage=0, error_timeout=1; clear_err -> IDLE (no done). valid_in ignored.
//  - valid_in outside IDLE, tx_finish outside TX_WAIT, clear_err outside ERROR: ignored.
//  - stall ignored outside FILL. Counters never wrap: cnt bounded by PHASE_LEN-1,
//    tmo by TX_TIMEOUT-1, burst_idx by nb-1.
// TESTING  (N_STAGES=3, PHASE_LEN=4, TX_TIMEOUT=8, TRIG 1..3)
//  1 Reset held 3 cycles, random inputs -> all outputs 0, busy=0.
//  2 valid_in, n_bursts=1 -> en_stage 001 x4, 011 x4, 111 x4; trigger high at cnt 1..3
//    of stage 0; start_tx 1 cycle; tx_finish 2 cycles later -> done pulse, busy=0.
//  3 stall 2 cycles mid stage 1 -> en_stage=000 during stall, stage 1 lasts 6 cycles.
//  4 n_bursts=3, RESTART_FILL=0 -> bursts 2,3 show en_stage=111 x4 then start_tx;
//    burst_idx 0,1,2; one done pulse.
//  5 No tx_finish -> error_timeout after 8 TX_WAIT cycles; valid_in ignored; clear_err -> IDLE.
//  6 n_bursts=0 -> one burst; rst_n low mid-FILL -> next cycle all outputs 0.

Source files
------------

// File: rtl/pipeline_seq_controller_if.sv
// Handshake bundle for pipeline_seq_controller.
//   Inputs to the controller: valid_in, n_bursts, stall, tx_finish, clear_err.
//   Outputs from the controller: en_stage, trigger, start_tx, done, busy,
//   error_timeout, burst_idx.
// master = the environment driving the sequencer; slave = the sequencer itself.
interface pipeline_seq_controller_if #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned BURST_W  = 8
);
  logic                valid_in;
  logic [BURST_W-1:0]  n_bursts;
  logic                stall;
  logic                tx_finish;
  logic                clear_err;
  logic [N_STAGES-1:0] en_stage;
  logic                trigger;
  logic                start_tx;
  logic                done;
  logic                busy;
  logic                error_timeout;
  logic [BURST_W-1:0]  burst_idx;

  modport master (
    output valid_in, n_bursts, stall, tx_finish, clear_err,
    input  en_stage, trigger, start_tx, done, busy, error_timeout, burst_idx
  );

  modport slave (
    input  valid_in, n_bursts, stall, tx_finish, clear_err,
    output en_stage, trigger, start_tx, done, busy, error_timeout, burst_idx
  );
endinterface

// File: rtl/pipeline_seq_controller.sv
// pipeline_seq_controller: sequencer for the encode/bus/decode test pipeline.
// Fills N_STAGES thermometer enable stages one PHASE_LEN-cycle phase at a time,
// raises a trigger window during the first phase of the first burst, hands off
// to the TX path and repeats for the requested number of bursts. A TX path that
// never finishes parks the sequencer in ERROR until clear_err.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset (aborts any operation)
//   sif    - slave side of pipeline_seq_controller_if:
//            valid_in/n_bursts start request, stall freezes the fill,
//            tx_finish ends TX_WAIT, clear_err leaves ERROR;
//            en_stage/trigger/start_tx/done/busy/error_timeout/burst_idx status.
module pipeline_seq_controller #(
  parameter int unsigned N_STAGES     = 5,
  parameter int unsigned PHASE_LEN    = 2048,
  parameter int unsigned TRIG_LO      = 1,
  parameter int unsigned TRIG_HI      = 3,
  parameter int unsigned BURST_W      = 8,
  parameter int unsigned TX_TIMEOUT   = 4096,
  parameter bit          RESTART_FILL = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  pipeline_seq_controller_if.slave sif
);

  localparam int unsigned CNT_W = $clog2(PHASE_LEN);
  localparam int unsigned TMO_W = $clog2(TX_TIMEOUT);
  localparam int unsigned STG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] TRIG_LO_C  = CNT_W'(TRIG_LO);
  localparam logic [CNT_W-1:0] TRIG_HI_C  = CNT_W'(TRIG_HI);
  localparam logic [TMO_W-1:0] LAST_TMO   = TMO_W'(TX_TIMEOUT - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_TX_WAIT,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] nb_q, nb_d;
  logic               start_tx_q, start_tx_d;
  logic               done_q, done_d;
  logic [N_STAGES-1:0] en_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stage_q    <= '0;
      tmo_q      <= '0;
      burst_q    <= '0;
      nb_q       <= '0;
      start_tx_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      tmo_q      <= tmo_d;
      burst_q    <= burst_d;
      nb_q       <= nb_d;
      start_tx_q <= start_tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    tmo_d      = tmo_q;
    burst_d    = burst_q;
    nb_d       = nb_q;
    start_tx_d = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sif.valid_in) begin
          state_d = S_FILL;
          nb_d    = (sif.n_bursts == '0) ? BURST_W'(1) : sif.n_bursts;
          cnt_d   = '0;
          stage_d = '0;
          burst_d = '0;
        end
      end
      S_FILL: begin
        if (!sif.stall) begin
          if (cnt_q == LAST_CNT) begin
            if (stage_q < LAST_STAGE) begin
              stage_d = stage_q + STG_W'(1);
              cnt_d   = '0;
            end else begin
              state_d    = S_TX_WAIT;
              tmo_d      = '0;
              start_tx_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_TX_WAIT: begin
        // tx_finish takes priority over the timeout on the same cycle.
        if (sif.tx_finish) begin
          if (burst_q == nb_q - BURST_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FILL;
            burst_d = burst_q + BURST_W'(1);
            cnt_d   = '0;
            stage_d = RESTART_FILL ? '0 : LAST_STAGE;
          end
        end else if (tmo_q == LAST_TMO) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_ERROR: begin
        if (sif.clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Thermometer: stages 0..stage_q enabled, all gated off while stalled.
  always_comb begin
    en_stage = '0;
    if (state_q == S_FILL && !sif.stall) begin
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        en_stage[i] = (i <= 32'(stage_q));
      end
    end
  end

  assign sif.en_stage      = en_stage;
  assign sif.trigger       = (state_q == S_FILL) && !sif.stall && (stage_q == '0) &&
                             (burst_q == '0) && (cnt_q >= TRIG_LO_C) && (cnt_q <= TRIG_HI_C);
  assign sif.start_tx      = start_tx_q;
  assign sif.done          = done_q;
  assign sif.busy          = (state_q != S_IDLE);
  assign sif.error_timeout = (state_q == S_ERROR);
  assign sif.burst_idx     = burst_q;

endmodule

// File: tb/tb_pipeline_seq_controller.sv
// Randomized bench for pipeline_seq_controller. Two instances share one input
// stream: one refills from stage 0 on every burst, the other runs later bursts
// at full depth. Each is checked every cycle against a burst/phase model that
// tracks fill progress as a single cycle position within the burst.
module tb_pipeline_seq_controller;

  localparam int unsigned NS  = 3;
  localparam int unsigned PL  = 4;
  localparam int unsigned TO  = 8;
  localparam int unsigned TLO = 1;
  localparam int unsigned THI = 3;
  localparam int unsigned BW  = 8;
  localparam int          N_CYCLES = 4000;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_TX   = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_seq_controller_if #(.N_STAGES(NS), .BURST_W(BW)) if_a ();
  pipeline_seq_controller_if #(.N_STAGES(NS), .BURST_W(BW)) if_b ();

  pipeline_seq_controller #(
    .N_STAGES(NS), .PHASE_LEN(PL), .TRIG_LO(TLO), .TRIG_HI(THI),
    .BURST_W(BW), .TX_TIMEOUT(TO), .RESTART_FILL(1'b1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .sif(if_a));

  pipeline_seq_controller #(
    .N_STAGES(NS), .PHASE_LEN(PL), .TRIG_LO(TLO), .TRIG_HI(THI),
    .BURST_W(BW), .TX_TIMEOUT(TO), .RESTART_FILL(1'b0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .sif(if_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Shared stimulus
  logic          valid_in, stall, tx_finish, clear_err;
  logic [BW-1:0] n_bursts;

  // Reference model state, index 0 = restart-fill instance, 1 = full-depth
  int mode [2];
  int pos  [2];   // cycles of fill completed in this burst
  int tmo  [2];
  int bidx [2];
  int nb   [2];
  bit ptx  [2];
  bit pdone[2];

  // Coverage-ish counters so the run exercises the interesting paths
  int n_done = 0, n_err = 0, n_trig = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    mode[k] = M_IDLE; pos[k] = 0; tmo[k] = 0; bidx[k] = 0; nb[k] = 1;
    ptx[k] = 1'b0; pdone[k] = 1'b0;
  endtask

  task automatic check_outputs(input int k, input logic [NS-1:0] en, input logic trig,
                               input logic stx, input logic dn, input logic bsy,
                               input logic err, input logic [BW-1:0] bi);
    int stage, c;
    logic [31:0] exp_en;
    logic exp_trig;
    string p;
    p = (k == 0) ? "a" : "b";
    stage = pos[k] / PL;
    c     = pos[k] % PL;
    exp_en   = (mode[k] == M_FILL && !stall) ? ((32'd1 << (stage + 1)) - 1) : 32'd0;
    exp_trig = (mode[k] == M_FILL) && !stall && stage == 0 && bidx[k] == 0 &&
               c >= TLO && c <= THI;
    check({p, ".en_stage"},      32'(en),   exp_en);
    check({p, ".trigger"},       32'(trig), 32'(exp_trig));
    check({p, ".start_tx"},      32'(stx),  32'(ptx[k]));
    check({p, ".done"},          32'(dn),   32'(pdone[k]));
    check({p, ".busy"},          32'(bsy),  32'(mode[k] != M_IDLE));
    check({p, ".error_timeout"}, 32'(err),  32'(mode[k] == M_ERR));
    check({p, ".burst_idx"},     32'(bi),   32'(bidx[k]));
    if (k == 0) begin
      if (dn) n_done++;
      if (err && mode[k] == M_ERR && tmo[k] == TO - 1) n_err++;
      if (trig) n_trig++;
    end
  endtask

  task automatic model_step(input int k, input bit restart_fill);
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    ptx[k]   = 1'b0;
    pdone[k] = 1'b0;
    case (mode[k])
      M_IDLE: if (valid_in) begin
        mode[k] = M_FILL;
        nb[k]   = (n_bursts == 0) ? 1 : int'(n_bursts);
        pos[k]  = 0;
        bidx[k] = 0;
      end
      M_FILL: if (!stall) begin
        if (pos[k] == NS * PL - 1) begin
          mode[k] = M_TX; tmo[k] = 0; ptx[k] = 1'b1;
        end else begin
          pos[k]++;
        end
      end
      M_TX: begin
        if (tx_finish) begin
          if (bidx[k] == nb[k] - 1) begin
            mode[k] = M_IDLE; pdone[k] = 1'b1;
          end else begin
            bidx[k]++;
            mode[k] = M_FILL;
            pos[k]  = restart_fill ? 0 : (NS - 1) * PL;
          end
        end else if (tmo[k] == TO - 1) begin
          mode[k] = M_ERR;
        end else begin
          tmo[k]++;
        end
      end
      default: if (clear_err) mode[k] = M_IDLE;
    endcase
  endtask

  task automatic drive();
    if_a.valid_in = valid_in;  if_b.valid_in = valid_in;
    if_a.n_bursts = n_bursts;  if_b.n_bursts = n_bursts;
    if_a.stall    = stall;     if_b.stall    = stall;
    if_a.tx_finish = tx_finish; if_b.tx_finish = tx_finish;
    if_a.clear_err = clear_err; if_b.clear_err = clear_err;
  endtask

  task automatic randomize_inputs(input bit allow_reset);
    valid_in  = ($urandom % 3) == 0;
    n_bursts  = BW'($urandom % 4);
    stall     = ($urandom % 5) == 0;
    tx_finish = ($urandom % 4) == 0;
    clear_err = ($urandom % 3) == 0;
    rst_n     = allow_reset ? (($urandom % 150) != 0) : 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      randomize_inputs(cyc >= 3);
      drive();
      #1;
      // Before the first reset edge the registers are still unknown.
      if (cyc > 0) begin
        check_outputs(0, if_a.en_stage, if_a.trigger, if_a.start_tx, if_a.done,
                      if_a.busy, if_a.error_timeout, if_a.burst_idx);
        check_outputs(1, if_b.en_stage, if_b.trigger, if_b.start_tx, if_b.done,
                      if_b.busy, if_b.error_timeout, if_b.burst_idx);
      end
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end
    check("activity.done_seen",    32'(n_done > 0), 32'd1);
    check("activity.timeout_seen", 32'(n_err > 0),  32'd1);
    check("activity.trigger_seen", 32'(n_trig > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
